jpeg_block_sequencer: RTL
=========================

# jpeg_block_sequencer

Per-block control FSM for the JPEG encoder datapath. It generates every strobe the encoder top level consumes: bulk load, DCT run, DCT capture, per-row quantize/zigzag write, zigzag commit, Huffman start. One 8x8 block is processed at a time. A host start/ready handshake sits on the upstream side, and a done/error report sits on the downstream side.

## Interface
- DCT_CYCLES, 4: cycles `dct_enable` is held high before the DCT result is captured (1..255).
- QUANT_LAT, 2: cycles from `matrix_row` change to valid quantizer row output (1..15).
- HUFF_TIMEOUT, 1024: maximum HUFF_WAIT cycles before a forced finish (1..65535).
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- block_start  in  1  host request to encode the block presented on `pix_data`.
- block_ready  out  1  high only in IDLE; `block_start` is accepted when both are high.
- soft_abort  in  1  synchronous abort of the block in flight.
- huffman_done  in  1  Huffman controller finished emitting the current block.
- input_enable  out  1  one-cycle bulk load of the input buffer.
- dct_enable  out  1  DCT run strobe.
- dct_end_enable  out  1  one-cycle capture of the DCT output into the quantize buffer.
- matrix_row  out  8  row index (0..7) driven to the quantizer and zigzag buffer.
- zigzag_input_enable  out  1  one-cycle write of the current quantized row.
- zigag_enable  out  1  one-cycle zigzag reorder commit.
- Huffman_start  out  1  one-cycle Huffman encode start.
- busy  out  1  high in every state except IDLE.
- block_done  out  1  one-cycle end-of-block pulse.
- timeout_err  out  1  set together with `block_done` if the Huffman wait timed out; cleared on the next accepted `block_start`.

## Operation
- States: IDLE, LOAD, DCT, DCT_END, Q_ROW, Q_WR, ZIGZAG, HUFF_START, HUFF_WAIT, DONE.
- All outputs are registered Moore decodes of the state and counters. There are no combinational input-to-output paths.
- IDLE: `block_ready`=1. On `block_start`=1, go to LOAD and clear `timeout_err`.
- LOAD: `input_enable`=1 for 1 cycle, then go to DCT.
- DCT: `dct_enable`=1 for exactly DCT_CYCLES cycles, counted by an 8-bit counter. Then go to DCT_END.
- DCT_END: `dct_end_enable`=1 for 1 cycle. Set row=0 and go to Q_ROW.
- Q_ROW: `matrix_row`=row, held for QUANT_LAT cycles, then go to Q_WR.
- Q_WR: `matrix_row`=row and `zigzag_input_enable`=1 for 1 cycle.
  - If row=7, go to ZIGZAG.
  - Otherwise increment row and go to Q_ROW.
  - `matrix_row` never exceeds 7. It wraps to 0 only through the IDLE/DCT_END path.
- ZIGZAG: `zigag_enable`=1 for 1 cycle, then go to HUFF_START.
- HUFF_START: `Huffman_start`=1 for 1 cycle. Clear the 16-bit wait counter and go to HUFF_WAIT.
- HUFF_WAIT: the wait counter increments each cycle.
  - On `huffman_done`=1, go to DONE.
  - Otherwise, once the counter reaches HUFF_TIMEOUT-1, go to DONE and set `timeout_err`.
  - If `huffman_done` arrives in the expiry cycle, `huffman_done` wins and `timeout_err` stays 0.
- DONE: `block_done`=1 for 1 cycle, then go to IDLE.
- `huffman_done` is ignored in every state except HUFF_WAIT.
- `block_start` is ignored whenever `busy`=1. It is not queued.
- `soft_abort`=1 in any non-IDLE state:
  - Next state is IDLE, all counters are cleared and all strobes are low the next cycle.
  - No `block_done` pulse is produced and `timeout_err` is unchanged.
  - `soft_abort` in IDLE has no effect and takes priority over a simultaneous `block_start`.
- At most one of the strobes (`input_enable`, `dct_end_enable`, `zigzag_input_enable`, `zigag_enable`, `Huffman_start`, `block_done`) is high in any cycle.

## Timing
- Reset (`reset_n`=0, asynchronous): state=IDLE and all counters 0.
  - Outputs: `block_ready`=1; `busy`=0; `matrix_row`=0; `timeout_err`=0; all strobes and `dct_enable`=0.
- `block_start` accepted in cycle T:
  - LOAD at T+1.
  - DCT at T+2 .. T+1+DCT_CYCLES.
  - DCT_END at T+2+DCT_CYCLES.
  - Row r occupies QUANT_LAT+1 cycles starting at T+3+DCT_CYCLES+r*(QUANT_LAT+1).
  - ZIGZAG at T+3+DCT_CYCLES+8*(QUANT_LAT+1), followed by HUFF_START.
- `huffman_done` first seen in HUFF_WAIT cycle W gives `block_done` at W+1 and `block_ready` at W+2.
- Minimum back-to-back block period is DCT_CYCLES+8*(QUANT_LAT+1)+7 cycles, with `huffman_done` in the first HUFF_WAIT cycle.
- `matrix_row` holds its last value (7) from ZIGZAG through DONE and returns to 0 in IDLE.
- Reset asserted mid-block forces the reset values immediately, regardless of clock.

## Test plan
- Reset mid-DCT (DCT_CYCLES=4, QUANT_LAT=2): assert `reset_n`=0 at T+3 -> all outputs at reset values without waiting for a clock edge; `block_ready`=1 after release.
- Nominal block (DCT_CYCLES=4, QUANT_LAT=2): `block_start` at T, `huffman_done` at T+33 ->
  - `input_enable` @T+1; `dct_enable` @T+2..T+5; `dct_end_enable` @T+6.
  - `zigzag_input_enable` at T+9, 12, ..., 30 with `matrix_row`=0..7.
  - `zigag_enable` @T+31; `Huffman_start` @T+32; `block_done` @T+34; `block_ready` @T+35.
- Timeout (HUFF_TIMEOUT=8, `huffman_done` never asserted) -> `block_done`=1 and `timeout_err`=1 exactly 9 cycles after `Huffman_start`. The next accepted `block_start` clears `timeout_err`.
- Done at expiry: `huffman_done` pulsed in the 8th HUFF_WAIT cycle with HUFF_TIMEOUT=8 -> `block_done` the next cycle with `timeout_err`=0.
- Abort and ignored start: `block_start` pulsed during Q_ROW is ignored. `soft_abort` during row 3 -> IDLE next cycle, no `block_done`, no further `zigzag_input_enable`, `matrix_row`=0.
- Strobe exclusivity: across 3 back-to-back blocks, assert every cycle that at most one strobe is high and that `matrix_row`≤7.

Source files
------------

// File: rtl/jpeg_block_sequencer_if.sv
// Host handshake and encoder strobe bundle for the JPEG per-block sequencer.
// master drives requests and huffman_done; slave (the sequencer) drives every strobe.
interface jpeg_block_sequencer_if;
  logic       block_start;
  logic       block_ready;
  logic       soft_abort;
  logic       huffman_done;
  logic       input_enable;
  logic       dct_enable;
  logic       dct_end_enable;
  logic [7:0] matrix_row;
  logic       zigzag_input_enable;
  logic       zigag_enable;
  logic       Huffman_start;
  logic       busy;
  logic       block_done;
  logic       timeout_err;

  modport master (
    output block_start, soft_abort, huffman_done,
    input  block_ready, input_enable, dct_enable, dct_end_enable, matrix_row,
           zigzag_input_enable, zigag_enable, Huffman_start, busy, block_done, timeout_err
  );

  modport slave (
    input  block_start, soft_abort, huffman_done,
    output block_ready, input_enable, dct_enable, dct_end_enable, matrix_row,
           zigzag_input_enable, zigag_enable, Huffman_start, busy, block_done, timeout_err
  );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// Per-block JPEG encoder control FSM: load, DCT, 8 quantize rows, zigzag, Huffman wait, done.
// All outputs registered from next-state; one block in flight, block_start ignored while busy.
module jpeg_block_sequencer #(
  parameter int DCT_CYCLES   = 4,
  parameter int QUANT_LAT    = 2,
  parameter int HUFF_TIMEOUT = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  jpeg_block_sequencer_if.slave  seq
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_DCT, ST_DCT_END, ST_Q_ROW,
    ST_Q_WR, ST_ZIGZAG, ST_HUFF_START, ST_HUFF_WAIT, ST_DONE
  } state_t;

  localparam logic [7:0]  DCT_LAST  = 8'(DCT_CYCLES - 1);
  localparam logic [3:0]  Q_LAST    = 4'(QUANT_LAT - 1);
  localparam logic [15:0] WAIT_LAST = 16'(HUFF_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [2:0]  row, row_nxt;
  logic [7:0]  dct_cnt, dct_cnt_nxt;
  logic [3:0]  q_cnt, q_cnt_nxt;
  logic [15:0] w_cnt, w_cnt_nxt;
  logic        terr_q, terr_nxt;

  logic ready_q, busy_q, in_en_q, dct_en_q, dend_q, zin_q, zz_q, hs_q, done_q;
  logic ready_nxt, busy_nxt, in_en_nxt, dct_en_nxt, dend_nxt, zin_nxt, zz_nxt, hs_nxt, done_nxt;

  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    dct_cnt_nxt = dct_cnt;
    q_cnt_nxt   = q_cnt;
    w_cnt_nxt   = w_cnt;
    terr_nxt    = terr_q;

    // Abort wins over everything outside IDLE and leaves timeout_err alone.
    if (state != ST_IDLE && seq.soft_abort) begin
      state_nxt   = ST_IDLE;
      row_nxt     = '0;
      dct_cnt_nxt = '0;
      q_cnt_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (seq.block_start && !seq.soft_abort) begin
            state_nxt = ST_LOAD;
            terr_nxt  = 1'b0;
          end
        end
        ST_LOAD: begin
          state_nxt   = ST_DCT;
          dct_cnt_nxt = '0;
        end
        ST_DCT: begin
          if (dct_cnt == DCT_LAST) begin
            state_nxt   = ST_DCT_END;
            dct_cnt_nxt = '0;
          end else begin
            dct_cnt_nxt = dct_cnt + 8'd1;
          end
        end
        ST_DCT_END: begin
          state_nxt = ST_Q_ROW;
          row_nxt   = '0;
          q_cnt_nxt = '0;
        end
        ST_Q_ROW: begin
          if (q_cnt == Q_LAST) begin
            state_nxt = ST_Q_WR;
            q_cnt_nxt = '0;
          end else begin
            q_cnt_nxt = q_cnt + 4'd1;
          end
        end
        ST_Q_WR: begin
          if (row == 3'd7) begin
            state_nxt = ST_ZIGZAG;
          end else begin
            state_nxt = ST_Q_ROW;
            row_nxt   = row + 3'd1;
          end
        end
        ST_ZIGZAG:     state_nxt = ST_HUFF_START;
        ST_HUFF_START: begin
          state_nxt = ST_HUFF_WAIT;
          w_cnt_nxt = '0;
        end
        ST_HUFF_WAIT: begin
          // A done arriving on the expiry cycle is a normal finish, not a timeout.
          if (seq.huffman_done) begin
            state_nxt = ST_DONE;
            w_cnt_nxt = '0;
          end else if (w_cnt == WAIT_LAST) begin
            state_nxt = ST_DONE;
            w_cnt_nxt = '0;
            terr_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
          row_nxt   = '0;
        end
        default: begin
          state_nxt = ST_IDLE;
          row_nxt   = '0;
        end
      endcase
    end

    // Moore decode of the next state so every output leaves a flop.
    ready_nxt  = (state_nxt == ST_IDLE);
    busy_nxt   = (state_nxt != ST_IDLE);
    in_en_nxt  = (state_nxt == ST_LOAD);
    dct_en_nxt = (state_nxt == ST_DCT);
    dend_nxt   = (state_nxt == ST_DCT_END);
    zin_nxt    = (state_nxt == ST_Q_WR);
    zz_nxt     = (state_nxt == ST_ZIGZAG);
    hs_nxt     = (state_nxt == ST_HUFF_START);
    done_nxt   = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      row      <= '0;
      dct_cnt  <= '0;
      q_cnt    <= '0;
      w_cnt    <= '0;
      terr_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      in_en_q  <= 1'b0;
      dct_en_q <= 1'b0;
      dend_q   <= 1'b0;
      zin_q    <= 1'b0;
      zz_q     <= 1'b0;
      hs_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      row      <= row_nxt;
      dct_cnt  <= dct_cnt_nxt;
      q_cnt    <= q_cnt_nxt;
      w_cnt    <= w_cnt_nxt;
      terr_q   <= terr_nxt;
      ready_q  <= ready_nxt;
      busy_q   <= busy_nxt;
      in_en_q  <= in_en_nxt;
      dct_en_q <= dct_en_nxt;
      dend_q   <= dend_nxt;
      zin_q    <= zin_nxt;
      zz_q     <= zz_nxt;
      hs_q     <= hs_nxt;
      done_q   <= done_nxt;
    end
  end

  assign seq.block_ready         = ready_q;
  assign seq.busy                = busy_q;
  assign seq.input_enable        = in_en_q;
  assign seq.dct_enable          = dct_en_q;
  assign seq.dct_end_enable      = dend_q;
  assign seq.matrix_row          = {5'd0, row};
  assign seq.zigzag_input_enable = zin_q;
  assign seq.zigag_enable        = zz_q;
  assign seq.Huffman_start       = hs_q;
  assign seq.block_done          = done_q;
  assign seq.timeout_err         = terr_q;

endmodule
